// File: rtl/ising_coupling_cell.sv
// Ising array crosspoint: two inertial delay lines whose delay follows the coupling weight.
// Define ISING_CELL_SYNC_IN_EN to put a 2-flop synchronizer on sin and din.
module ising_coupling_cell #(
  parameter int SHORTED  = 0,
  parameter int NOM_DLY  = 4,
  parameter int FAST_DLY = 2,
  parameter int SLOW_DLY = 6,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] weight,
  input  logic       sin,
  input  logic       din,
  output logic       sout,
  output logic       dout
);

  localparam logic [CNT_W-1:0] NOM_M1  = CNT_W'(NOM_DLY - 1);
  localparam logic [CNT_W-1:0] FAST_M1 = CNT_W'(FAST_DLY - 1);
  localparam logic [CNT_W-1:0] SLOW_M1 = CNT_W'(SLOW_DLY - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic s_in;
  logic d_in;

`ifdef ISING_CELL_SYNC_IN_EN
  logic [1:0] s_sync_q, s_sync_d;
  logic [1:0] d_sync_q, d_sync_d;

  always_comb begin
    s_sync_d = {s_sync_q[0], sin};
    d_sync_d = {d_sync_q[0], din};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s_sync_q <= '0;
      d_sync_q <= '0;
    end else begin
      s_sync_q <= s_sync_d;
      d_sync_q <= d_sync_d;
    end
  end

  assign s_in = s_sync_q[1];
  assign d_in = d_sync_q[1];
`else
  assign s_in = sin;
  assign d_in = din;
`endif

  // index 0 is the s path, index 1 the d path
  logic [1:0]       src;
  logic [1:0]       ptr;
  logic [1:0]       o_q, o_d;
  logic [1:0]       pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  function automatic logic [CNT_W-1:0] dly_m1(
    input logic [2:0] w,
    input logic       al
  );
    logic [CNT_W-1:0] r;
    if (SHORTED != 0) r = NOM_M1;
    else if (w[2])    r = al ? FAST_M1 : SLOW_M1;
    else if (w[1])    r = NOM_M1;
    else              r = al ? SLOW_M1 : FAST_M1;
    return r;
  endfunction

  always_comb begin
    if (SHORTED != 0) begin
      src = {s_in, d_in};
      ptr = {d_in, s_in};
    end else begin
      src = {d_in, s_in};
      ptr = {s_in, d_in};
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      o_d[p]    = o_q[p];
      pend_d[p] = pend_q[p];
      cnt_d[p]  = cnt_q[p];
      if (pend_q[p]) begin
        // source back at the output value: swallow the short pulse
        if (src[p] == o_q[p]) begin
          pend_d[p] = 1'b0;
          cnt_d[p]  = '0;
        end else if (cnt_q[p] == ONE) begin
          o_d[p]    = src[p];
          pend_d[p] = 1'b0;
          cnt_d[p]  = '0;
        end else begin
          cnt_d[p] = cnt_q[p] - ONE;
        end
      end else if (src[p] != o_q[p]) begin
        cnt_d[p] = dly_m1(weight, src[p] == ptr[p]);
        if (cnt_d[p] == '0) o_d[p] = src[p];
        else pend_d[p] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_q    <= '0;
      pend_q <= '0;
      for (int p = 0; p < 2; p++) cnt_q[p] <= '0;
    end else begin
      o_q    <= o_d;
      pend_q <= pend_d;
      for (int p = 0; p < 2; p++) cnt_q[p] <= cnt_d[p];
    end
  end

  assign sout = o_q[0];
  assign dout = o_q[1];

endmodule

// File: tb/tb_ising_coupling_cell.sv
// Directed bench for ising_coupling_cell: coupled and shorted instances.
// Latencies count rising edges from an input change to the output change.
module tb_ising_coupling_cell;

`ifdef ISING_CELL_SYNC_IN_EN
  localparam int SY = 2;
`else
  localparam int SY = 0;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] wa, wb;
  logic       sa, da, sb, db;
  logic       a_sout, a_dout, b_sout, b_dout;

  int checks   = 0;
  int failures = 0;
  int n, hi, first_hi;

  always #5 clk = ~clk;

  ising_coupling_cell #(.SHORTED(0)) u_a (
    .clk(clk), .rstn(rstn), .weight(wa),
    .sin(sa), .din(da), .sout(a_sout), .dout(a_dout)
  );

  ising_coupling_cell #(.SHORTED(1)) u_b (
    .clk(clk), .rstn(rstn), .weight(wb),
    .sin(sb), .din(db), .sout(b_sout), .dout(b_dout)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return a_sout;
      1:       return a_dout;
      2:       return b_sout;
      default: return b_dout;
    endcase
  endfunction

  // edges until the selected output changes; 99 on timeout
  task automatic lat(input int sel, output int k);
    logic v0;
    v0 = pick(sel);
    k = 99;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (pick(sel) !== v0) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic settle();
    repeat (14) @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0;
    wa = 3'b010; wb = 3'b100;
    sa = 1'b1; da = 1'b1; sb = 1'b1; db = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_a_sout", a_sout, 0);
    chk("rst_a_dout", a_dout, 0);
    chk("rst_b_sout", b_sout, 0);
    chk("rst_b_dout", b_dout, 0);

    rstn = 1'b1;
    lat(0, n);
    chk("rel_lat", n, 4 + SY);
    chk("rel_a_dout", a_dout, 1);
    chk("rel_b_sout", b_sout, 1);
    chk("rel_b_dout", b_dout, 1);

    sa = 1'b0; da = 1'b0; settle();
    wa = 3'b100; da = 1'b1; settle();
    sa = 1'b1; lat(0, n);
    chk("pos_al", n, 2 + SY);
    sa = 1'b0; settle();
    da = 1'b0; settle();
    sa = 1'b1; lat(0, n);
    chk("pos_opp", n, 6 + SY);

    sa = 1'b0; settle();
    wa = 3'b000; da = 1'b1; settle();
    sa = 1'b1; lat(0, n);
    chk("neg_al", n, 6 + SY);
    sa = 1'b0; settle();
    da = 1'b0; settle();
    sa = 1'b1; lat(0, n);
    chk("neg_opp", n, 2 + SY);

    da = 1'b1; lat(1, n);
    chk("d_neg_al", n, 6 + SY);
    sa = 1'b0; settle();
    da = 1'b0; settle();
    da = 1'b1; lat(1, n);
    chk("d_neg_opp", n, 2 + SY);
    wa = 3'b100; da = 1'b0; lat(1, n);
    chk("d_pos_al", n, 2 + SY);

    wa = 3'b010; da = 1'b1; settle();
    sa = 1'b1; lat(0, n);
    chk("unc_010", n, 4 + SY);
    wa = 3'b011; sa = 1'b0; lat(0, n);
    chk("unc_011", n, 4 + SY);
    wa = 3'b110; sa = 1'b1; lat(0, n);
    chk("w110_pos", n, 2 + SY);

    wa = 3'b010; sa = 1'b0; settle();
    da = 1'b0; settle();
    sa = 1'b1; hi = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 1) sa = 1'b0;
      hi += int'(a_sout);
    end
    chk("pulse2_hi", hi, 0);

    settle();
    sa = 1'b1; hi = 0; first_hi = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 3) sa = 1'b0;
      if (a_sout && first_hi < 0) first_hi = i;
      hi += int'(a_sout);
    end
    chk("pulse4_start", first_hi, 3 + SY);
    chk("pulse4_width", hi, 4);

    settle();
    wa = 3'b000; da = 1'b1; settle();
    sa = 1'b1; n = 99;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 4 + SY) wa = 3'b100;
      if (a_sout) begin
        n = i;
        break;
      end
    end
    chk("latched_d", n, 6 + SY);

    db = 1'b0; lat(2, n);
    chk("sh_sout_fall", n, 4 + SY);
    sb = 1'b0; lat(3, n);
    chk("sh_dout_fall", n, 4 + SY);
    db = 1'b1; lat(2, n);
    chk("sh_sout_rise", n, 4 + SY);

    sb = 1'b1;
    repeat (2 + SY) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("sh_rst_sout", b_sout, 0);
    chk("sh_rst_dout", b_dout, 0);
    rstn = 1'b1;
    lat(3, n);
    chk("sh_post_rst", n, 4 + SY);
    chk("sh_post_sout", b_sout, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ising_coupling_cell.md
# ising_coupling_cell

Clocked coupling element for the digital Ising oscillator array. It carries two oscillator signals through one crosspoint, the s path and the d path. Each output is a delayed copy of its input. The delay is shortened or lengthened according to the programmed coupling weight and the phase relationship between the two oscillators. In shorted mode (diagonal crosspoints) it instead joins the horizontal and vertical rings of one spin with a fixed delay.

## Interface
Parameters:
- SHORTED, 0: 0 selects coupled mode (off-diagonal cell); 1 selects shorted mode (diagonal cell).
- NOM_DLY, 4: delay in cycles when uncoupled, and in shorted mode.
- FAST_DLY, 2: delay in cycles when the transition is favoured.
- SLOW_DLY, 6: delay in cycles when the transition is opposed.
- CNT_W, 4: width of the delay counters. Each delay must satisfy 1 ≤ DLY ≤ 2^CNT_W−1.

Ports:
- clk  in  1  single clock; every register updates on the rising edge.
- rstn  in  1  reset, synchronous and active-low.
- weight  in  3  coupling code:
  - weight[2]=1 → positive coupling (highest priority).
  - else weight[1]=1 → uncoupled.
  - else → negative coupling.
  - Ignored when SHORTED=1.
- sin  in  1  s-path oscillator input.
- din  in  1  d-path oscillator input.
- sout  out  1  s-path output, registered.
- dout  out  1  d-path output, registered.

## Operation
- Each path has an output register `o`, a down-counter `cnt`, and a pending flag.
- Source and partner per path:
  - Coupled mode: s path source=sin, partner=din; d path source=din, partner=sin.
  - Shorted mode: sout source=din, dout source=sin (cross connection); there is no partner term.
- At each edge, when no transition is pending and source≠o:
  - Select delay D from the table below.
  - Load cnt=D−1 and set pending.
  - If D=1, o takes the source value at this edge and no transition becomes pending.
- Delay selection, with aligned = (source == partner):
  - Positive coupling: aligned → FAST_DLY, else SLOW_DLY.
  - Negative coupling: aligned → SLOW_DLY, else FAST_DLY.
  - Uncoupled, or shorted mode: NOM_DLY.
- While pending:
  - If source==o, the transition is cancelled and pending clears (inertial delay: pulses shorter than D are swallowed).
  - Otherwise cnt decrements; at the edge where cnt==0, o<=source and pending clears.
- D is latched at launch. Later changes on the partner or on weight do not alter an in-flight transition.
- The two paths are fully independent except for the partner comparison.

## Timing
- Reset (rstn=0 at an edge): sout=0, dout=0, counters 0, pending clear. Reset wins over every other event, including a mid-countdown transition.
- First edge with rstn=1: inputs are evaluated normally. An input held at 1 through reset therefore produces output 1 after D cycles.
- Latency: an input change sampled at edge t appears on the output at edge t+D−1, i.e. visible D cycles after the input settles.
- Simultaneous sin and din changes at the same edge: each path compares against the partner value sampled at that same edge.
- A source toggle that occurs exactly at the expiry edge: the output takes the value present at that edge.

## Configuration
- ISING_CELL_SYNC_IN_EN:
  - Defined: sin and din each pass through a 2-flop synchronizer (reset to 0) before all logic, including partner comparisons. All latencies increase by 2 cycles.
  - Not defined: inputs are sampled directly, and must be synchronous to clk.

## Test plan
- Reset: hold rstn=0 with sin=din=1 for 5 cycles → sout=dout=0. Release rstn in uncoupled mode → both outputs go to 1 after NOM_DLY=4 cycles.
- Positive coupling, weight=3'b100, din=1, toggle sin 0→1 → sout rises after 2 cycles. With din=0, the same toggle → 6 cycles.
- Negative coupling, weight=3'b000, din=1, toggle sin 0→1 → 6 cycles. With din=0 → 2 cycles. Repeat symmetrically on the d path against sin.
- Uncoupled, weight=3'b010 (also 3'b011, 3'b110 resolves as positive): any toggle → 4 cycles, regardless of partner value.
- Inertial filter: in uncoupled mode, a 2-cycle pulse on sin → sout never changes. A 4-cycle pulse → sout shows a 4-cycle pulse delayed by 4.
- Shorted, SHORTED=1, weight=3'b100: toggle din → sout follows in 4 cycles. Toggle sin → dout follows in 4 cycles. Assert rstn=0 mid-countdown → both outputs 0 next edge, and no stale transition appears after release.
